// File: rtl/sysbus_arb_pkg.sv
// ============================================================================
// Module : sysbus_arb_pkg
// Brief  : Shared bus constants, command encodings and field widths for
//          the slot-based system bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sysbus_arb_pkg;

  localparam int c_bus_beats = 8;
  localparam int c_bus_linew = 26;
  localparam int c_beatw     = $clog2(c_bus_beats);
  localparam int c_cmdw      = 3;
  localparam int c_tagw      = 5;
  localparam int c_dataw     = 64;

  typedef enum logic [c_cmdw-1:0] {
    CMD_NOP  = 3'd0,
    CMD_RD   = 3'd1,
    CMD_RDX  = 3'd2,
    CMD_WB   = 3'd3,
    CMD_UPG  = 3'd4,
    CMD_IORD = 3'd5,
    CMD_IOWR = 3'd6,
    CMD_INV  = 3'd7
  } bus_cmd_e;

endpackage

`default_nettype wire

// File: rtl/sysbus_arb_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Rotating priority encoder; returns the first set request at or
//          above the pointer, wrapping modulo NREQ.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [PTRW-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // Pointer is always below NREQ, so a single wrap suffices.
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_idx       = PTRW'(j);
        o_onehot[j] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sysbus_arb.sv
// ============================================================================
// Module : sysbus_arb
// Brief  : Slot arbiter/sequencer for the 8-beat snooping system bus:
//          beat counter, round-robin grant, owner pipeline, broadcast mux.
//          Optional perf counters when SYSBUS_ARB_PERF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sysbus_arb
  import sysbus_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  input  logic [c_cmdw*NREQ-1:0]   cmd_i,
  input  logic [c_tagw*NREQ-1:0]   tag_i,
  input  logic [c_bus_linew*NREQ-1:0] addr_i,
  input  logic [c_dataw*NREQ-1:0]  data_i,
  input  logic [NREQ-1:0]          nack_i,
  input  logic [NREQ-1:0]          hit_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [c_beatw-1:0]       bus_cycle,
  output logic                     bus_valid,
  output logic [c_cmdw-1:0]        bus_cmd,
  output logic [c_tagw-1:0]        bus_tag,
  output logic [c_bus_linew-1:0]   bus_addr,
  output logic [c_dataw-1:0]       bus_data,
  output logic                     bus_nack,
  output logic                     bus_hit
`ifdef SYSBUS_ARB_PERF_EN
  ,
  output logic [31:0]              perf_busy_o,
  output logic [31:0]              perf_nack_o,
  output logic [31:0]              perf_idle_o
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [c_beatw-1:0] r_cycle;
  logic [NREQ-1:0]    r_grant;
  logic [NREQ-1:0]    r_owner;
  logic [PTRW-1:0]    r_ptr;

  logic               w_last;
  logic [NREQ-1:0]    w_elig;
  logic [NREQ-1:0]    w_win_oh;
  logic [PTRW-1:0]    w_win_idx;
  logic               w_win_any;
  logic [PTRW-1:0]    w_ptr_next;

  assign w_last = (r_cycle == c_beatw'(c_bus_beats - 1));
  // Current grantee's req is stale until it reloads on its own beat-7 edge.
  assign w_elig = req_i & ~r_grant;
  assign w_ptr_next = (w_win_idx == PTRW'(NREQ - 1)) ? '0 : w_win_idx + PTRW'(1);

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr_pick (
    .i_req    (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_cycle <= r_cycle + c_beatw'(1);
      if (w_last) begin
        r_owner <= r_grant;
        r_grant <= w_win_any ? w_win_oh : '0;
        if (w_win_any) r_ptr <= w_ptr_next;
      end
    end
  end

  logic [c_cmdw-1:0]      w_cmd;
  logic [c_tagw-1:0]      w_tag;
  logic [c_bus_linew-1:0] w_addr;
  logic [c_dataw-1:0]     w_data;

  // Owner is one-hot or zero, so an OR of gated fields is the mux.
  always_comb begin
    w_cmd  = '0;
    w_tag  = '0;
    w_addr = '0;
    w_data = '0;
    for (int m = 0; m < NREQ; m++) begin
      if (r_owner[m]) begin
        w_cmd  = w_cmd  | cmd_i[m*c_cmdw +: c_cmdw];
        w_tag  = w_tag  | tag_i[m*c_tagw +: c_tagw];
        w_addr = w_addr | addr_i[m*c_bus_linew +: c_bus_linew];
        w_data = w_data | data_i[m*c_dataw +: c_dataw];
      end
    end
  end

  assign grant_o   = r_grant;
  assign bus_cycle = r_cycle;
  assign bus_valid = |r_owner;
  assign bus_cmd   = w_cmd;
  assign bus_tag   = w_tag;
  assign bus_addr  = w_addr;
  assign bus_data  = w_data;
  assign bus_nack  = |nack_i;
  assign bus_hit   = |hit_i;

`ifdef SYSBUS_ARB_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_nack;
  logic [31:0] r_perf_idle;
  logic        r_nack_seen;
  logic        w_slot_nack;

  assign w_slot_nack = r_nack_seen | bus_nack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_busy <= '0;
      r_perf_nack <= '0;
      r_perf_idle <= '0;
      r_nack_seen <= 1'b0;
    end else begin
      // Beat 0 restarts the sticky flag for the new slot.
      if (r_cycle == '0) r_nack_seen <= bus_nack;
      else               r_nack_seen <= w_slot_nack;
      if (w_last) begin
        if (bus_valid) r_perf_busy <= r_perf_busy + 32'd1;
        else           r_perf_idle <= r_perf_idle + 32'd1;
        if (bus_valid && w_slot_nack) r_perf_nack <= r_perf_nack + 32'd1;
      end
    end
  end

  assign perf_busy_o = r_perf_busy;
  assign perf_nack_o = r_perf_nack;
  assign perf_idle_o = r_perf_idle;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sysbus_arb.sv
// ============================================================================
// Module : tb_sysbus_arb
// Brief  : Directed plus randomized bench for sysbus_arb against an
//          index-based slot model of the bus (SYSBUS_ARB_PERF_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sysbus_arb;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, nack_i, hit_i;
  logic [3*N-1:0]  cmd_i;
  logic [5*N-1:0]  tag_i;
  logic [26*N-1:0] addr_i;
  logic [64*N-1:0] data_i;
  logic [N-1:0]    grant_o;
  logic [2:0]      bus_cycle;
  logic            bus_valid, bus_nack, bus_hit;
  logic [2:0]      bus_cmd;
  logic [4:0]      bus_tag;
  logic [25:0]     bus_addr;
  logic [63:0]     bus_data;
`ifdef SYSBUS_ARB_PERF_EN
  logic [31:0]     perf_busy_o, perf_nack_o, perf_idle_o;
`endif

  sysbus_arb #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cmd_i(cmd_i), .tag_i(tag_i),
    .addr_i(addr_i), .data_i(data_i), .nack_i(nack_i), .hit_i(hit_i),
    .grant_o(grant_o), .bus_cycle(bus_cycle), .bus_valid(bus_valid),
    .bus_cmd(bus_cmd), .bus_tag(bus_tag), .bus_addr(bus_addr),
    .bus_data(bus_data), .bus_nack(bus_nack), .bus_hit(bus_hit)
`ifdef SYSBUS_ARB_PERF_EN
    , .perf_busy_o(perf_busy_o), .perf_nack_o(perf_nack_o), .perf_idle_o(perf_idle_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: beat number, granted master, owning master (-1 = none), rotation start.
  int          m_cyc, m_grant, m_owner, m_ptr;
  int unsigned m_busy, m_nack, m_idle;
  bit          m_slot_nack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++)
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_edge();
    logic [N-1:0] elig;
    int w;
    if (rst) begin
      m_cyc = 0; m_grant = -1; m_owner = -1; m_ptr = 0;
      m_busy = 0; m_nack = 0; m_idle = 0; m_slot_nack = 0;
    end else begin
      if (m_cyc == 7) begin
        if (m_owner >= 0) begin
          m_busy++;
          if (m_slot_nack || (|nack_i)) m_nack++;
        end else begin
          m_idle++;
        end
        m_slot_nack = 0;
        elig = req_i;
        if (m_grant >= 0) elig[m_grant] = 1'b0;
        w = pick(elig, m_ptr);
        m_owner = m_grant;
        m_grant = w;
        if (w >= 0) m_ptr = (w + 1) % N;
      end else if (|nack_i) begin
        m_slot_nack = 1;
      end
      m_cyc = (m_cyc + 1) % 8;
    end
  endtask

  task automatic check_all();
    logic [63:0] eg;
    eg = (m_grant >= 0) ? (64'd1 << m_grant) : 64'd0;
    chk("grant", grant_o, eg);
    chk("grant_onehot0", 64'($onehot0(grant_o)), 64'd1);
    chk("cycle", bus_cycle, m_cyc);
    chk("valid", bus_valid, (m_owner >= 0) ? 64'd1 : 64'd0);
    chk("cmd",  bus_cmd,  (m_owner >= 0) ? 64'(cmd_i[3*m_owner +: 3])   : 64'd0);
    chk("tag",  bus_tag,  (m_owner >= 0) ? 64'(tag_i[5*m_owner +: 5])   : 64'd0);
    chk("addr", bus_addr, (m_owner >= 0) ? 64'(addr_i[26*m_owner +: 26]) : 64'd0);
    chk("data", bus_data, (m_owner >= 0) ? data_i[64*m_owner +: 64]     : 64'd0);
    chk("nack", bus_nack, 64'(|nack_i));
    chk("hit",  bus_hit,  64'(|hit_i));
`ifdef SYSBUS_ARB_PERF_EN
    chk("perf_busy", perf_busy_o, m_busy);
    chk("perf_nack", perf_nack_o, m_nack);
    chk("perf_idle", perf_idle_o, m_idle);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
    check_all();
  endtask

  task automatic to_beat(input int b);
    for (int i = 0; i < 16 && m_cyc != b; i++) tick();
    chk("reach_beat", bus_cycle, b);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      cmd_i[3*i +: 3]   = 3'($urandom);
      tag_i[5*i +: 5]   = 5'($urandom);
      addr_i[26*i +: 26] = 26'($urandom);
      data_i[64*i +: 64] = {$urandom, $urandom};
    end
  endtask

  logic [N-1:0] t3_exp [5];

  initial begin
    rst = 1'b1; req_i = '0; nack_i = '0; hit_i = '0;
    cmd_i = '0; tag_i = '0; addr_i = '0; data_i = '0;
    m_cyc = 0; m_grant = -1; m_owner = -1; m_ptr = 0;
    m_busy = 0; m_nack = 0; m_idle = 0; m_slot_nack = 0;
    rand_fields();
    do_reset(2);

    // Reset in the middle of a slot with grant and owner live
    req_i = 4'b1111;
    repeat (19) begin tick(); rand_fields(); end
    rst = 1'b1;
    tick();
    chk("rst_grant", grant_o, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_cycle", bus_cycle, 0);
    chk("rst_tag", bus_tag, 0);
    tick(); tick();
    rst = 1'b0; req_i = '0;

    // Single request from beat 7 of slot 0
    tag_i = {5'h03, 5'h15, 5'h0A, 5'h1F};
    to_beat(7);
    req_i = 4'b0100;
    tick();
    req_i = '0;
    for (int b = 0; b < 8; b++) begin
      chk("t2_grant", grant_o, 4'b0100);
      chk("t2_nobus", bus_valid, 0);
      tick();
    end
    for (int b = 0; b < 8; b++) begin
      chk("t2_valid", bus_valid, 1);
      chk("t2_tag", bus_tag, 5'h15);
      chk("t2_grant_off", grant_o, 0);
      tick();
    end

    // All masters requesting: strict rotation
    do_reset(1);
    t3_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    to_beat(7);
    req_i = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t3_grant", grant_o, t3_exp[s]);
      if (s > 0) chk("t3_norepeat", grant_o & t3_exp[s-1], 0);
      to_beat(7);
    end
    req_i = '0;

    // Lone master holding req across edges is masked every other slot
    do_reset(1);
    to_beat(7);
    req_i = 4'b0010;
    tick();
    chk("t4_slot1", grant_o, 4'b0010);
    to_beat(7);
    tick();
    chk("t4_slot2", grant_o, 4'b0000);
    to_beat(7);
    tick();
    chk("t4_slot3", grant_o, 4'b0010);
    req_i = '0;

    // Snoop response OR
    to_beat(4);
    nack_i = 4'b0010; hit_i = 4'b0000;
    #1;
    chk("t5_nack", bus_nack, 1);
    chk("t5_hit", bus_hit, 0);
    tick();
    nack_i = '0;

`ifdef SYSBUS_ARB_PERF_EN
    // Two idle slots, then three owned slots with one nacked
    do_reset(1);
    chk("t6_busy0", perf_busy_o, 0);
    to_beat(7);
    req_i = 4'b0011;
    tick(); to_beat(7);
    tick(); to_beat(7);
    tick();
    req_i = '0;
    to_beat(3);
    nack_i = 4'b0100;
    tick();
    nack_i = '0;
    to_beat(7); tick();
    to_beat(7); tick();
    chk("t6_busy", perf_busy_o, 3);
    chk("t6_nack", perf_nack_o, 1);
    chk("t6_idle", perf_idle_o, 2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      req_i  = N'($urandom & $urandom);
      nack_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      hit_i  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rst    = ($urandom_range(0, 199) == 0);
      rand_fields();
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
